// File: rtl/fifo_word_unpacker.sv
// Drains an FWFT FIFO and splits each FIFO word into WBITS-wide operands on a valid/ready port.
// Define UNPACK_MSB_FIRST_EN to emit the most significant slot first (default: least significant first).
module fifo_word_unpacker #(
   parameter int DINWIDTH = 16,
   parameter int WBITS    = 4,
   parameter int WCOUNT   = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DINWIDTH-1:0] fifo_dout,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   output logic [WBITS-1:0]    word_out,
   output logic                word_valid,
   input  logic                word_ready,
   output logic                word_last,
   output logic                vec_done
);

   localparam int NPW   = DINWIDTH / WBITS;
   localparam int NIB_W = (NPW > 1) ? $clog2(NPW) : 1;
   localparam int WC_W  = $clog2(WCOUNT);

   localparam logic [0:0] HOLD_EMPTY = 1'b0;
   localparam logic [0:0] HOLD_FULL  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [DINWIDTH-1:0]   hold_q, hold_d;
   logic [NIB_W-1:0]      nib_idx_q, nib_idx_d;
   logic [WC_W-1:0]       wcnt_q, wcnt_d;
   logic                  vec_done_q, vec_done_d;

   logic                  accept, nib_last, wcnt_last, pop;
   logic [NIB_W-1:0]      slot_idx;
   logic [NPW-1:0][WBITS-1:0] slots;

   assign slots = hold_q;

`ifdef UNPACK_MSB_FIRST_EN
   assign slot_idx = NIB_W'(NPW - 1) - nib_idx_q;
`else
   assign slot_idx = nib_idx_q;
`endif

   always_comb begin
      word_valid = (state_q == HOLD_FULL);
      accept     = word_valid & word_ready;
      nib_last   = (nib_idx_q == NIB_W'(NPW - 1));
      wcnt_last  = (wcnt_q == WC_W'(WCOUNT - 1));
      word_out   = slots[slot_idx];
      word_last  = word_valid & wcnt_last;

      state_d    = state_q;
      hold_d     = hold_q;
      nib_idx_d  = nib_idx_q;
      pop        = 1'b0;

      case (state_q)
         HOLD_EMPTY: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               hold_d    = fifo_dout;
               nib_idx_d = '0;
               state_d   = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (accept) begin
               if (!nib_last) begin
                  nib_idx_d = nib_idx_q + 1'b1;
               end else if (!fifo_empty) begin
                  // Reload on the last slot so a full FIFO streams without a bubble.
                  pop       = 1'b1;
                  hold_d    = fifo_dout;
                  nib_idx_d = '0;
               end else begin
                  state_d   = HOLD_EMPTY;
               end
            end
         end
         default: state_d = HOLD_EMPTY;
      endcase

      wcnt_d = wcnt_q;
      if (accept) wcnt_d = wcnt_last ? '0 : wcnt_q + 1'b1;
      vec_done_d = accept & wcnt_last;

      // The FIFO is flushed alongside us, so never pop while reset is held.
      fifo_rd_en = pop & rst;
   end

   assign vec_done = vec_done_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= HOLD_EMPTY;
         hold_q     <= '0;
         nib_idx_q  <= '0;
         wcnt_q     <= '0;
         vec_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         nib_idx_q  <= nib_idx_d;
         wcnt_q     <= wcnt_d;
         vec_done_q <= vec_done_d;
      end
   end

endmodule
